// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider with two round-robin divisor requesters; a new divisor is applied only at a period boundary.
// Optional macro CLKDIV_ERR_EN: reject divisors below 2 with an err pulse instead of clamping them to 2.
module clk_div_ctrl #(
  parameter int                WIDTH       = 32,
  parameter logic [WIDTH-1:0]  DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_div,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_div,
  output logic             req1_ready,
  output logic [WIDTH-1:0] div_o,
  output logic             out,
  output logic             tick,
  output logic             busy,
  output logic             upd_done,
  output logic             grant_id
`ifdef CLKDIV_ERR_EN
  ,
  output logic             err
`endif
);

  localparam logic IDLE = 1'b0;
  localparam logic PEND = 1'b1;

  logic             state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend_div;
  logic [WIDTH-1:0] div_last;
  logic             accept;
  logic [WIDTH-1:0] acc_div;
  logic             at_end;

  assign div_last = div_o - WIDTH'(1);
  assign at_end   = (cnt == div_last);
  assign busy     = (state == PEND);

  // Ties go to the requester that was not granted last.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && state == IDLE) begin
      if (req0_valid && (!req1_valid || grant_id)) req0_ready = 1'b1;
      else if (req1_valid)                         req1_ready = 1'b1;
    end
  end

  assign accept  = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign acc_div = req0_ready ? req0_div : req1_div;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      div_o    <= DEFAULT_DIV;
      pend_div <= DEFAULT_DIV;
      grant_id <= 1'b1;
      out      <= 1'b0;
      tick     <= 1'b0;
      upd_done <= 1'b0;
`ifdef CLKDIV_ERR_EN
      err      <= 1'b0;
`endif
    end else begin
      out      <= (cnt < (div_o >> 1));
      tick     <= at_end;
      upd_done <= 1'b0;
`ifdef CLKDIV_ERR_EN
      err      <= 1'b0;
`endif
      // Only a request already pending before this edge may be applied here.
      if (state == PEND && at_end) begin
        div_o    <= pend_div;
        cnt      <= '0;
        state    <= IDLE;
        upd_done <= 1'b1;
      end else begin
        cnt <= at_end ? '0 : cnt + WIDTH'(1);
      end
      if (accept) begin
        grant_id <= req1_ready;
`ifdef CLKDIV_ERR_EN
        if (acc_div < WIDTH'(2)) begin
          err <= 1'b1;
        end else begin
          pend_div <= acc_div;
          state    <= PEND;
        end
`else
        pend_div <= (acc_div < WIDTH'(2)) ? WIDTH'(2) : acc_div;
        state    <= PEND;
`endif
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios then random traffic, compared each cycle against a period-level reference model.
module tb_clk_div_ctrl;
  localparam int W   = 32;
  localparam int DEF = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_div, req1_div;
  logic         req0_ready, req1_ready;
  logic [W-1:0] div_o;
  logic         out, tick, busy, upd_done, grant_id;
`ifdef CLKDIV_ERR_EN
  logic         err;
`endif

  always #5 clk = ~clk;

  clk_div_ctrl #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_div(req0_div), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_div(req1_div), .req1_ready(req1_ready),
    .div_o(div_o), .out(out), .tick(tick), .busy(busy),
    .upd_done(upd_done), .grant_id(grant_id)
`ifdef CLKDIV_ERR_EN
    , .err(err)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: position within the current period plus the queued divisor.
  int unsigned m_div, m_pos, m_pdiv;
  bit          m_pend, m_gid;
  bit          e_out, e_tick, e_upd, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div = DEF; m_pos = 0; m_pdiv = DEF; m_pend = 0; m_gid = 1;
    e_out = 0; e_tick = 0; e_upd = 0; e_err = 0;
  endtask

  task automatic cycle();
    bit          g0, g1, last;
    int unsigned d;
    #1;
    g0 = 0; g1 = 0;
    if (rst_n && !m_pend) begin
      if (req0_valid && (!req1_valid || m_gid)) g0 = 1;
      else if (req1_valid)                      g1 = 1;
    end
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("div_o", div_o, m_div);
    chk("out", out, e_out);
    chk("tick", tick, e_tick);
    chk("busy", busy, m_pend);
    chk("upd_done", upd_done, e_upd);
    chk("grant_id", grant_id, m_gid);
`ifdef CLKDIV_ERR_EN
    chk("err", err, e_err);
`endif
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      last   = (m_pos == m_div - 1);
      e_out  = (m_pos < m_div / 2);
      e_tick = last;
      e_upd  = 0;
      e_err  = 0;
      d      = g0 ? req0_div : req1_div;
      if (m_pend && last) begin
        m_div = m_pdiv; m_pos = 0; m_pend = 0; e_upd = 1;
      end else begin
        m_pos = last ? 0 : m_pos + 1;
      end
      if (g0 || g1) begin
        m_gid = g1;
        if (d < 2) begin
`ifdef CLKDIV_ERR_EN
          e_err = 1;
`else
          m_pdiv = 2; m_pend = 1;
`endif
        end else begin
          m_pdiv = d; m_pend = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int unsigned saved_div;
    int          guard;
    rst_n = 0; req0_valid = 0; req1_valid = 0; req0_div = '0; req1_div = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    run(2);

    // Free-running default divisor.
    rst_n = 1;
    run(8);

    // Single request to divide by 4.
    req0_valid = 1; req0_div = 4;
    cycle();
    req0_valid = 0; req0_div = 9;
    run(12);
    chk("div_after_req4", div_o, 4);

    // Simultaneous requests after reset: req0 wins the first tie.
    rst_n = 0; run(1); rst_n = 1;
    req0_valid = 1; req0_div = 3; req1_valid = 1; req1_div = 5;
    cycle();
    chk("gid_first_tie", grant_id, 0);
    run(20);
    req0_valid = 0; req1_valid = 0;
    run(12);

    // Illegal divisor.
    saved_div = m_div;
    req1_valid = 1; req1_div = 1;
    cycle();
    req1_valid = 0;
    run(12);
`ifdef CLKDIV_ERR_EN
    chk("div_after_illegal", div_o, saved_div);
`else
    chk("div_after_clamp", div_o, 2);
`endif

    // Reset while a divisor of 7 is pending.
    guard = 0;
    while (busy && guard < 50) begin cycle(); guard++; end
    chk("idle_before_pend7", busy, 0);
    req0_valid = 1; req0_div = 7;
    cycle();
    req0_valid = 0;
    rst_n = 0; run(1); rst_n = 1;
    run(10);
    chk("div_after_rst_pend", div_o, DEF);

    // Random traffic including illegal divisors and occasional resets.
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(0, 2) == 0);
      req1_valid = ($urandom_range(0, 2) == 0);
      req0_div   = $urandom_range(0, 9);
      req1_div   = $urandom_range(0, 9);
      rst_n      = ($urandom_range(0, 59) != 0);
      cycle();
    end
    rst_n = 1; req0_valid = 0; req1_valid = 0;
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, divisor width in bits.
REQ-002 Parameter DEFAULT_DIV, default 2, divisor loaded at reset (SHALL be >= 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req0_valid / req1_valid  input  1 each  requester n offers a new divisor.
REQ-006 req0_div / req1_div  input  WIDTH each  requested divisor from requester n.
REQ-007 req0_ready / req1_ready  output  1 each  request n accepted this cycle when valid && ready.
REQ-008 div_o  output  WIDTH  divisor currently in effect.
REQ-009 out  output  1  divided clock-enable level, registered.
REQ-010 tick  output  1  one-cycle pulse in last cycle of each divided period, registered.
REQ-011 busy  output  1  high while an accepted divisor awaits application.
REQ-012 upd_done  output  1  one-cycle pulse when a new divisor takes effect.
REQ-013 grant_id  output  1  index of last accepted requester.
REQ-014 err  output  1  one-cycle pulse on rejected divisor (present only with CLKDIV_ERR_EN).

Function
REQ-015 Phase counter cnt SHALL count 0..div_o-1, wrapping to 0; out SHALL be 1 when cnt < floor(div_o/2), else 0; tick SHALL be 1 when cnt == div_o-1; out/tick registered, one cycle after cnt.
REQ-016 Resulting periods: div=2 -> out 1,0; div=3 -> 1,0,0; div=4 -> 1,1,0,0; tick coincides with last out sample of each period.
REQ-017 FSM states IDLE, PEND; IDLE -> PEND on accepted legal request; PEND -> IDLE in the cycle cnt == div_o-1.
REQ-018 Ready SHALL assert only in IDLE, to exactly one requester, combinationally from valid and the arbiter pointer; never both readies high.
REQ-019 Arbitration round-robin: only one valid -> grant it; both valid -> grant the one not equal to grant_id; grant_id resets to 1 so req0 wins first tie.
REQ-020 Accepted divisor SHALL be held in pend_div; requester inputs may change after handshake.
REQ-021 On PEND exit, div_o <= pend_div and cnt <= 0 in the same edge; new period starts next cycle; upd_done pulses that next cycle.
REQ-022 A request accepted in the cycle cnt == div_o-1 SHALL apply at the following period end, never the same edge.
REQ-023 busy SHALL equal (state == PEND); no request accepted while busy.
REQ-024 div_o arithmetic unsigned WIDTH bits; cnt WIDTH bits; no overflow since cnt < div_o.

Reset
REQ-025 While rst_n low at an edge: state IDLE, cnt 0, div_o DEFAULT_DIV, pend_div DEFAULT_DIV, grant_id 1, out/tick/upd_done/err 0; readies 0.
REQ-026 Reset mid-PEND SHALL discard the pending divisor without upd_done.
REQ-027 First cycle after release: cnt 0; out/tick follow from second cycle per REQ-015.

Configuration
REQ-028 Macro CLKDIV_ERR_EN defined: request with div < 2 completes handshake, is not loaded, FSM stays IDLE, err pulses next cycle.
REQ-029 CLKDIV_ERR_EN undefined: err port absent; div < 2 is clamped to 2 and processed as a legal request.

Verification
REQ-030 Reset, DEFAULT_DIV=2, no requests -> out 1,0,1,0...; tick every 2nd cycle with out=0; div_o=2.
REQ-031 Running div 2, req0 div=4 -> req0_ready same cycle, busy until period end, upd_done once, div_o=4, out 1,1,0,0.
REQ-032 After reset, req0=3 and req1=5 valid together, held -> req0 first (div_o=3, out 1,0,0), then req1 (div_o=5, out 1,1,0,0,0), grant_id 0 then 1.
REQ-033 req1 div=1 -> with CLKDIV_ERR_EN: err one cycle, div_o unchanged, upd_done 0; without: div_o=2 after period end.
REQ-034 rst_n low for one cycle while busy with pend_div=7 -> after release div_o=DEFAULT_DIV, busy 0, no upd_done.
